// File: rtl/servo_cmd_rx_if.sv
// Serial input and decoded command/group outputs of the servo command receiver.
interface servo_cmd_rx_if;
  logic        uart_rxd;
  logic        cmd_valid;
  logic [9:0]  cmd_id;
  logic [13:0] cmd_pwm;
  logic [13:0] cmd_time;
  logic [2:0]  cmd_idx;
  logic        grp_valid;
  logic [13:0] grp_num;
  logic        frame_err;
  logic        rx_busy;

  // Receiver side: consumes the serial line, produces decoded commands.
  modport master (
    input  uart_rxd,
    output cmd_valid, cmd_id, cmd_pwm, cmd_time, cmd_idx,
    output grp_valid, grp_num, frame_err, rx_busy
  );

  // Consumer side: drives the serial line, observes decoded commands.
  modport slave (
    output uart_rxd,
    input  cmd_valid, cmd_id, cmd_pwm, cmd_time, cmd_idx,
    input  grp_valid, grp_num, frame_err, rx_busy
  );
endinterface

// File: rtl/servo_cmd_rx.sv
// UART 8N1 receiver plus parser for "G000n" group headers and
// "#iiiPppppTtttt!" servo commands; emits binary ID/PWM/time fields.
module servo_cmd_rx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  servo_cmd_rx_if.master bus
);
  localparam int unsigned BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int unsigned HALF_CNT = BPS_CNT / 2;
  localparam int unsigned CNT_W    = $clog2(BPS_CNT);
  localparam logic [CNT_W-1:0] BPS_LAST  = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

  localparam logic [7:0] CH_G    = 8'h47;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_BANG = 8'h21;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, G_DIG, ID_DIG, EXP_P, PWM_DIG, EXP_T, T_DIG, EXP_BANG} p_state_t;

  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_stb, stop_err;

  p_state_t    p_state_q, p_state_d;
  logic [13:0] acc_q, acc_d, acc_next;
  logic [1:0]  dcnt_q, dcnt_d;
  logic [9:0]  id_hold_q, id_hold_d;
  logic [13:0] pwm_hold_q, pwm_hold_d, time_hold_q, time_hold_d;
  logic [2:0]  idx_q, idx_d;
  logic        cmd_valid_q, cmd_valid_d, grp_valid_q, grp_valid_d, frame_err_q, frame_err_d;
  logic [9:0]  cmd_id_q, cmd_id_d;
  logic [13:0] cmd_pwm_q, cmd_pwm_d, cmd_time_q, cmd_time_d, grp_num_q, grp_num_d;
  logic [2:0]  cmd_idx_q, cmd_idx_d;
  logic [7:0]  rx_byte;
  logic        is_digit, clr, syn_err;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= bus.uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Bit-level receive state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
    end
  end

  // Bit-level receive: mid-bit sampling, LSB-first shift, stop-bit check.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_stb   = 1'b0;
    stop_err   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rxd_prev_q && !rxd_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF_LAST) begin
        cnt_d      = '0;
        bit_d      = '0;
        rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == BPS_LAST) begin
        cnt_d   = '0;
        shift_d = {rxd_sync_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == BPS_LAST) begin
        cnt_d      = '0;
        rx_state_d = RX_IDLE;
        byte_stb   = rxd_sync_q;
        stop_err   = !rxd_sync_q;
      end
    endcase
  end

  assign rx_byte  = shift_q;
  assign is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
  assign acc_next = acc_q * 14'd10 + {10'd0, rx_byte[3:0]};

  // Parser state, accumulators and registered output fields.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      p_state_q   <= P_IDLE;
      acc_q       <= '0;
      dcnt_q      <= '0;
      id_hold_q   <= '0;
      pwm_hold_q  <= '0;
      time_hold_q <= '0;
      idx_q       <= '0;
      cmd_valid_q <= 1'b0;
      grp_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_id_q    <= '0;
      cmd_pwm_q   <= '0;
      cmd_time_q  <= '0;
      cmd_idx_q   <= '0;
      grp_num_q   <= '0;
    end else begin
      p_state_q   <= p_state_d;
      acc_q       <= acc_d;
      dcnt_q      <= dcnt_d;
      id_hold_q   <= id_hold_d;
      pwm_hold_q  <= pwm_hold_d;
      time_hold_q <= time_hold_d;
      idx_q       <= idx_d;
      cmd_valid_q <= cmd_valid_d;
      grp_valid_q <= grp_valid_d;
      frame_err_q <= frame_err_d;
      cmd_id_q    <= cmd_id_d;
      cmd_pwm_q   <= cmd_pwm_d;
      cmd_time_q  <= cmd_time_d;
      cmd_idx_q   <= cmd_idx_d;
      grp_num_q   <= grp_num_d;
    end
  end

  // Byte-level parser; syntax errors resynchronise on '#' or 'G'.
  always_comb begin
    p_state_d   = p_state_q;
    acc_d       = acc_q;
    dcnt_d      = dcnt_q;
    id_hold_d   = id_hold_q;
    pwm_hold_d  = pwm_hold_q;
    time_hold_d = time_hold_q;
    idx_d       = idx_q;
    cmd_valid_d = 1'b0;
    grp_valid_d = 1'b0;
    frame_err_d = 1'b0;
    cmd_id_d    = cmd_id_q;
    cmd_pwm_d   = cmd_pwm_q;
    cmd_time_d  = cmd_time_q;
    cmd_idx_d   = cmd_idx_q;
    grp_num_d   = grp_num_q;
    clr         = 1'b0;
    syn_err     = 1'b0;
    if (stop_err) begin
      frame_err_d = 1'b1;
      p_state_d   = P_IDLE;
    end else if (byte_stb) begin
      unique case (p_state_q)
        P_IDLE: begin
          if (rx_byte == CH_G) begin
            p_state_d = G_DIG;
            clr       = 1'b1;
            idx_d     = '0;
          end else if (rx_byte == CH_HASH) begin
            p_state_d = ID_DIG;
            clr       = 1'b1;
          end
        end
        G_DIG, ID_DIG, PWM_DIG, T_DIG: begin
          if (!is_digit) begin
            syn_err = 1'b1;
          end else begin
            acc_d  = acc_next;
            dcnt_d = dcnt_q + 2'd1;
            if (dcnt_q == ((p_state_q == ID_DIG) ? 2'd2 : 2'd3)) begin
              unique case (p_state_q)
                G_DIG: begin
                  grp_num_d   = acc_next;
                  grp_valid_d = 1'b1;
                  p_state_d   = P_IDLE;
                end
                ID_DIG: begin
                  id_hold_d = acc_next[9:0];
                  p_state_d = EXP_P;
                end
                PWM_DIG: begin
                  pwm_hold_d = acc_next;
                  p_state_d  = EXP_T;
                end
                default: begin
                  time_hold_d = acc_next;
                  p_state_d   = EXP_BANG;
                end
              endcase
            end
          end
        end
        EXP_P: begin
          if (rx_byte == CH_P) begin
            p_state_d = PWM_DIG;
            clr       = 1'b1;
          end else syn_err = 1'b1;
        end
        EXP_T: begin
          if (rx_byte == CH_T) begin
            p_state_d = T_DIG;
            clr       = 1'b1;
          end else syn_err = 1'b1;
        end
        EXP_BANG: begin
          if (rx_byte == CH_BANG) begin
            cmd_id_d    = id_hold_q;
            cmd_pwm_d   = pwm_hold_q;
            cmd_time_d  = time_hold_q;
            cmd_idx_d   = idx_q;
            cmd_valid_d = 1'b1;
            idx_d       = (idx_q == 3'd7) ? idx_q : idx_q + 3'd1;
            p_state_d   = P_IDLE;
          end else syn_err = 1'b1;
        end
      endcase
      if (syn_err) begin
        frame_err_d = 1'b1;
        if (rx_byte == CH_HASH) begin
          p_state_d = ID_DIG;
          clr       = 1'b1;
        end else if (rx_byte == CH_G) begin
          p_state_d = G_DIG;
          clr       = 1'b1;
          idx_d     = '0;
        end else begin
          p_state_d = P_IDLE;
        end
      end
    end
    if (clr) begin
      acc_d  = '0;
      dcnt_d = '0;
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_id    = cmd_id_q;
  assign bus.cmd_pwm   = cmd_pwm_q;
  assign bus.cmd_time  = cmd_time_q;
  assign bus.cmd_idx   = cmd_idx_q;
  assign bus.grp_valid = grp_valid_q;
  assign bus.grp_num   = grp_num_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = (rx_state_q != RX_IDLE);
endmodule

// File: tb/tb_servo_cmd_rx.sv
// Bench for servo_cmd_rx: directed UART byte streams, a template-matching
// reference model and a per-cycle event checker.
module tb_servo_cmd_rx;
  localparam int unsigned CLK_FREQ = 3200000;
  localparam int unsigned UART_BPS = 100000;
  localparam int BPS  = CLK_FREQ / UART_BPS;
  localparam int HALF = BPS / 2;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  servo_cmd_rx_if bus();

  servo_cmd_rx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int kind;  // 0 command, 1 group header, 2 error
    int id, pwm, tm, idx, grp;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pend[$];
  int         m_idx = 0;
  string      cmd_t, grp_t;

  int vectors = 0, miscompares = 0;
  int cmd_seen = 0, grp_seen = 0, err_seen = 0;
  int last_id = 0, last_pwm = 0, last_time = 0, last_idx = 0, last_grp = 0;

  function automatic void chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic int num(input int from, input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v = v * 10 + int'(pend[from + i]) - 48;
    return v;
  endfunction

  function automatic bit fits(input logic [7:0] t, input logic [7:0] b);
    if (t == 8'h44) return (b >= 8'h30) && (b <= 8'h39);
    return b == t;
  endfunction

  function automatic void start_frame(input logic [7:0] b);
    pend.delete();
    if (b == 8'h23) pend.push_back(b);
    else if (b == 8'h47) begin
      pend.push_back(b);
      m_idx = 0;
    end
  endfunction

  function automatic void push_err();
    ev_t e = '{kind: 2, id: 0, pwm: 0, tm: 0, idx: 0, grp: 0};
    exp_q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    string tmpl;
    ev_t   e;
    if (!stop_ok) begin
      push_err();
      pend.delete();
      return;
    end
    if (pend.size() == 0) begin
      start_frame(b);
      return;
    end
    tmpl = (pend[0] == 8'h23) ? cmd_t : grp_t;
    if (!fits(tmpl[pend.size()], b)) begin
      push_err();
      start_frame(b);
      return;
    end
    pend.push_back(b);
    if (pend.size() == tmpl.len()) begin
      e = '{kind: 0, id: 0, pwm: 0, tm: 0, idx: 0, grp: 0};
      if (pend[0] == 8'h23) begin
        e.id  = num(1, 3);
        e.pwm = num(5, 4);
        e.tm  = num(10, 4);
        e.idx = m_idx;
        m_idx = (m_idx < 7) ? m_idx + 1 : 7;
      end else begin
        e.kind = 1;
        e.grp  = num(1, 4);
      end
      exp_q.push_back(e);
      pend.delete();
    end
  endfunction

  // ---------------- event checker ----------------
  int  mon_k, mon_np;
  ev_t mon_e;
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      mon_np = int'(bus.cmd_valid) + int'(bus.grp_valid) + int'(bus.frame_err);
      if (mon_np > 1) chk("exclusive_pulses", mon_np, 1);
      if (mon_np >= 1) begin
        mon_k = bus.cmd_valid ? 0 : (bus.grp_valid ? 1 : 2);
        if (mon_k == 0) begin
          cmd_seen++;
          last_id = int'(bus.cmd_id);
          last_pwm = int'(bus.cmd_pwm);
          last_time = int'(bus.cmd_time);
          last_idx = int'(bus.cmd_idx);
        end else if (mon_k == 1) begin
          grp_seen++;
          last_grp = int'(bus.grp_num);
        end else err_seen++;
        if (exp_q.size() == 0) chk("unexpected_event_kind", mon_k, -1);
        else begin
          mon_e = exp_q.pop_front();
          chk("event_kind", mon_k, mon_e.kind);
          if (mon_k == 0 && mon_e.kind == 0) begin
            chk("cmd_id", int'(bus.cmd_id), mon_e.id);
            chk("cmd_pwm", int'(bus.cmd_pwm), mon_e.pwm);
            chk("cmd_time", int'(bus.cmd_time), mon_e.tm);
            chk("cmd_idx", int'(bus.cmd_idx), mon_e.idx);
          end else if (mon_k == 1 && mon_e.kind == 1) begin
            chk("grp_num", int'(bus.grp_num), mon_e.grp);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    bus.uart_rxd = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    bus.uart_rxd = 1'b0;
    repeat (BPS) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = b[i];
      repeat (BPS) @(negedge sys_clk);
    end
    bus.uart_rxd = stop_ok;
    repeat (BPS) @(negedge sys_clk);
    bus.uart_rxd = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic drain(input string name);
    idle(BPS);
    chk({name, "_pending_events"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_cmd_valid"}, int'(bus.cmd_valid), 0);
    chk({name, "_cmd_id"}, int'(bus.cmd_id), 0);
    chk({name, "_cmd_pwm"}, int'(bus.cmd_pwm), 0);
    chk({name, "_cmd_time"}, int'(bus.cmd_time), 0);
    chk({name, "_cmd_idx"}, int'(bus.cmd_idx), 0);
    chk({name, "_grp_valid"}, int'(bus.grp_valid), 0);
    chk({name, "_grp_num"}, int'(bus.grp_num), 0);
    chk({name, "_frame_err"}, int'(bus.frame_err), 0);
    chk({name, "_rx_busy"}, int'(bus.rx_busy), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int c0, g0, e0;
  initial begin
    cmd_t = "#DDDPDDDDTDDDD!";
    grp_t = "GDDDD";
    bus.uart_rxd = 1'b1;
    repeat (5) @(negedge sys_clk);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    idle(4 * BPS);

    // 1: single command
    c0 = cmd_seen; e0 = err_seen;
    send_str("#001P1500T1000!");
    drain("t1");
    chk("t1_cmd_count", cmd_seen - c0, 1);
    chk("t1_err_count", err_seen - e0, 0);
    chk("t1_id", last_id, 1);
    chk("t1_pwm", last_pwm, 1500);
    chk("t1_time", last_time, 1000);
    chk("t1_idx", last_idx, 0);

    // 2: group header and five back-to-back commands
    c0 = cmd_seen; g0 = grp_seen; e0 = err_seen;
    send_str("G0003#000P1500T1000!#001P1500T1000!#002P1900T1000!#003P0730T1000!#005P1500T1000!");
    drain("t2");
    chk("t2_grp_count", grp_seen - g0, 1);
    chk("t2_grp_num", last_grp, 3);
    chk("t2_cmd_count", cmd_seen - c0, 5);
    chk("t2_err_count", err_seen - e0, 0);
    chk("t2_last_idx", last_idx, 4);
    chk("t2_last_id", last_id, 5);

    // 3: bad separator, then a good command
    c0 = cmd_seen; e0 = err_seen;
    send_str("#001X1500T1000!#002P0900T0500!");
    drain("t3");
    chk("t3_err_count", err_seen - e0, 1);
    chk("t3_cmd_count", cmd_seen - c0, 1);
    chk("t3_id", last_id, 2);
    chk("t3_pwm", last_pwm, 900);
    chk("t3_time", last_time, 500);
    chk("t3_idx", last_idx, 5);

    // 4: resynchronise on an unexpected '#'
    c0 = cmd_seen; e0 = err_seen;
    send_str("#00#003P2500T1000!");
    drain("t4");
    chk("t4_err_count", err_seen - e0, 1);
    chk("t4_cmd_count", cmd_seen - c0, 1);
    chk("t4_id", last_id, 3);
    chk("t4_pwm", last_pwm, 2500);
    chk("t4_idx", last_idx, 6);

    // 5a: stop bit low on the 'T' byte
    c0 = cmd_seen; e0 = err_seen;
    send_str("#004P1500");
    send_byte(8'h54, 1'b0);
    idle(2 * BPS);
    send_str("1000!");
    drain("t5");
    chk("t5_err_count", err_seen - e0, 1);
    chk("t5_cmd_count", cmd_seen - c0, 0);

    // 5b: short low glitch on an idle line is a false start
    c0 = cmd_seen; g0 = grp_seen; e0 = err_seen;
    bus.uart_rxd = 1'b0;
    repeat (6) @(negedge sys_clk);
    chk("glitch_busy_high", int'(bus.rx_busy), 1);
    repeat (HALF / 2 - 6) @(negedge sys_clk);
    idle(3 * BPS);
    chk("glitch_busy_low", int'(bus.rx_busy), 0);
    chk("glitch_events", (cmd_seen - c0) + (grp_seen - g0) + (err_seen - e0), 0);

    // 6: reset mid-command, then a clean command
    send_str("#00");
    idle(2);
    sys_rst_n = 1'b0;
    exp_q.delete();
    pend.delete();
    m_idx = 0;
    repeat (5) @(negedge sys_clk);
    check_all_zero("midreset");
    sys_rst_n = 1'b1;
    idle(BPS);
    c0 = cmd_seen; e0 = err_seen;
    send_str("#007P1234T0042!");
    drain("t6");
    chk("t6_cmd_count", cmd_seen - c0, 1);
    chk("t6_err_count", err_seen - e0, 0);
    chk("t6_id", last_id, 7);
    chk("t6_pwm", last_pwm, 1234);
    chk("t6_time", last_time, 42);
    chk("t6_idx", last_idx, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
